// File: rtl/gear_error_corrector_if.sv
// rtl/gear_error_corrector_if.sv - request/result bundle for the GeAr error corrector
interface gear_if #(
  parameter int WIDTH = 16,
  parameter int IW    = 2,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] approx_sum;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic [IW-1:0]    err_cnt;
  logic             err_flag;
  logic [CNT_W-1:0] total_err;
  logic             clr_total;

  modport slave (
    input  in_valid, A, B, approx_sum, out_ready, clr_total,
    output in_ready, out_valid, sum, err_cnt, err_flag, total_err
  );

  modport master (
    output in_valid, A, B, approx_sum, out_ready, clr_total,
    input  in_ready, out_valid, sum, err_cnt, err_flag, total_err
  );
endinterface

// File: rtl/gear_error_corrector.sv
// rtl/gear_error_corrector.sv - multi-cycle exact correction of a GeAr approximate sum
module gear_error_corrector #(
  parameter  int R     = 4,
  parameter  int P     = 4,
  parameter  int WIDTH = 16,
  parameter  int CNT_W = 16,
  localparam int L     = R + P,
  localparam int K     = 1 + (WIDTH - L) / R,
  localparam int IW    = (K > 1) ? $clog2(K) : 1
) (
  input logic   clk,
  input logic   rst_n,
  gear_if.slave bus
);

  if (WIDTH < L || ((WIDTH - L) % R) != 0) begin : g_bad_params
    $error("gear_error_corrector: WIDTH must be >= R+P and (WIDTH-R-P) a multiple of R");
  end

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] total_q, total_d;

  int               base;
  logic [WIDTH-1:0] s_sh, a_sh, b_sh;
  logic [WIDTH-1:0] fld_mask, fld_new;
  logic [R-1:0]     field_inc;
  logic             carry_in, propagate, win_err;
  logic             handshake;

  // Evaluate the current window: the bit at the window base is already exact, so
  // the true carry into it falls out of S^A^B; if it propagates through all P
  // prediction bits, the window's R result bits missed that carry.
  always_comb begin
    base      = int'(idx_q) * R;
    s_sh      = s_q >> base;
    a_sh      = a_q >> base;
    b_sh      = b_q >> base;
    carry_in  = s_sh[0] ^ a_sh[0] ^ b_sh[0];
    propagate = &(a_sh[P-1:0] ^ b_sh[P-1:0]);
    win_err   = carry_in & propagate;
    field_inc = s_sh[P +: R] + 1'b1;
    fld_mask  = {{(WIDTH-R){1'b0}}, {R{1'b1}}} << (base + P);
    fld_new   = {{(WIDTH-R){1'b0}}, field_inc} << (base + P);
  end

  // Control FSM: capture in IDLE, fix one window per cycle in CHECK, hold in DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.A;
          b_d     = bus.B;
          s_d     = bus.approx_sum;
          idx_d   = IW'(1);
          cnt_d   = '0;
          state_d = (K > 1) ? CHECK : DONE;
        end
      end
      CHECK: begin
        if (win_err) begin
          // Field increment wraps inside the window; higher windows get their own
          // carry check on later cycles.
          s_d   = (s_q & ~fld_mask) | fld_new;
          cnt_d = cnt_q + 1'b1;
        end
        if (idx_q == IW'(K - 1)) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Cumulative count of erroneous results; clear wins over a same-cycle increment.
  always_comb begin
    handshake = (state_q == DONE) && bus.out_ready;
    total_d   = total_q;
    if (bus.clr_total) begin
      total_d = '0;
    end else if (handshake && (cnt_q != '0) && (total_q != {CNT_W{1'b1}})) begin
      total_d = total_q + 1'b1;
    end
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = s_q;
  assign bus.err_cnt   = cnt_q;
  assign bus.err_flag  = (cnt_q != '0);
  assign bus.total_err = total_q;

endmodule

// File: tb/tb_gear_error_corrector.sv
// tb/tb_gear_error_corrector.sv - self-checking bench for gear_error_corrector
module tb_gear_error_corrector;

  localparam int R = 4;
  localparam int P = 4;
  localparam int W = 16;
  localparam int K = 1 + (W - R - P) / R;

  logic        clk;
  logic        rst_n;
  logic        in_valid, out_ready, clr;
  logic [15:0] a, b, ap;

  int n_checks;
  int n_pass;
  int exp_t0;
  int exp_t1;

  gear_if #(.WIDTH(16), .IW(2), .CNT_W(16)) bus0 ();
  gear_if #(.WIDTH(16), .IW(2), .CNT_W(2))  bus1 ();

  assign bus0.in_valid   = in_valid;
  assign bus0.A          = a;
  assign bus0.B          = b;
  assign bus0.approx_sum = ap;
  assign bus0.out_ready  = out_ready;
  assign bus0.clr_total  = clr;
  assign bus1.in_valid   = in_valid;
  assign bus1.A          = a;
  assign bus1.B          = b;
  assign bus1.approx_sum = ap;
  assign bus1.out_ready  = out_ready;
  assign bus1.clr_total  = clr;

  gear_error_corrector #(.R(4), .P(4), .WIDTH(16), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  gear_error_corrector #(.R(4), .P(4), .WIDTH(16), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s/%s: got 0x%0h required 0x%0h", tag, name, got, exp);
  endtask

  // Behavioural GeAr adder: each window adds its L bits with no carry-in; window 0
  // keeps all L result bits, later windows keep their top R bits.
  function automatic logic [15:0] gear_approx(input logic [15:0] a_i, input logic [15:0] b_i);
    int ai, bi, win, res;
    ai  = int'(a_i);
    bi  = int'(b_i);
    res = 0;
    for (int j = 0; j < K; j++) begin
      win = (((ai >> (j * R)) & ((1 << (R + P)) - 1)) + ((bi >> (j * R)) & ((1 << (R + P)) - 1)))
            & ((1 << (R + P)) - 1);
      if (j == 0) res = win;
      else        res = res | ((win >> P) << (j * R + P));
    end
    return res[15:0];
  endfunction

  // A window is wrong when the exact carry into its base is 1 and all P prediction
  // bits propagate it.
  function automatic int expected_errs(input logic [15:0] a_i, input logic [15:0] b_i);
    int ai, bi, carries, n;
    ai      = int'(a_i);
    bi      = int'(b_i);
    carries = (ai + bi) ^ ai ^ bi;
    n       = 0;
    for (int j = 1; j < K; j++) begin
      if (((carries >> (j * R)) & 1) == 1 &&
          (((ai ^ bi) >> (j * R)) & ((1 << P) - 1)) == ((1 << P) - 1)) n++;
    end
    return n;
  endfunction

  // Starts #1 after a rising edge with the DUT idle; ends the same way.
  task automatic run_txn(input string tag, input logic [15:0] a_i, input logic [15:0] b_i,
                         input logic [15:0] ap_i, input logic [15:0] exp_sum,
                         input int exp_cnt, input int hold, input bit do_clr);
    int lat;
    logic [15:0] held;
    check(tag, "in_ready_idle", 32'(bus0.in_ready), 32'd1);
    a = a_i; b = b_i; ap = ap_i; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!bus0.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check(tag, "latency", 32'(lat), 32'(K - 1));
    check(tag, "sum", 32'(bus0.sum), 32'(exp_sum));
    check(tag, "err_cnt", 32'(bus0.err_cnt), 32'(exp_cnt));
    check(tag, "err_flag", 32'(bus0.err_flag), 32'(exp_cnt != 0));
    check(tag, "sum_cnt2", 32'(bus1.sum), 32'(exp_sum));
    held = bus0.sum;
    for (int h = 0; h < hold; h++) begin
      a = 16'($urandom); b = 16'($urandom); ap = 16'($urandom); in_valid = 1'b1;
      @(posedge clk); #1;
      check(tag, "hold_valid", 32'(bus0.out_valid), 32'd1);
      check(tag, "hold_sum", 32'(bus0.sum), 32'(held));
      check(tag, "hold_in_ready", 32'(bus0.in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    clr = do_clr;
    @(posedge clk); #1;
    out_ready = 1'b0;
    clr = 1'b0;
    if (do_clr) begin
      exp_t0 = 0;
      exp_t1 = 0;
    end else if (exp_cnt != 0) begin
      exp_t0 = (exp_t0 < 65535) ? exp_t0 + 1 : 65535;
      exp_t1 = (exp_t1 < 3) ? exp_t1 + 1 : 3;
    end
    check(tag, "post_out_valid", 32'(bus0.out_valid), 32'd0);
    check(tag, "post_in_ready", 32'(bus0.in_ready), 32'd1);
    check(tag, "total_err", 32'(bus0.total_err), 32'(exp_t0));
    check(tag, "total_err_cnt2", 32'(bus1.total_err), 32'(exp_t1));
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] ap;
    logic [15:0] sum;
    int          cnt;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [15:0] ra, rb;
    n_checks = 0; n_pass = 0; exp_t0 = 0; exp_t1 = 0;
    in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0;
    a = '0; b = '0; ap = '0;

    vecs[0] = '{16'h1234, 16'h0101, 16'h1335, 16'h1335, 0};
    vecs[1] = '{16'h00FF, 16'h0001, 16'h0000, 16'h0100, 1};
    vecs[2] = '{16'hFFFF, 16'h0001, 16'hFF00, 16'h0000, 2};
    vecs[3] = '{16'h7FF0, 16'h0010, 16'h7000, 16'h8000, 1};
    vecs[4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 16'hFFFE, 0};

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", "out_valid", 32'(bus0.out_valid), 32'd0);
    check("reset", "sum", 32'(bus0.sum), 32'd0);
    check("reset", "err_cnt", 32'(bus0.err_cnt), 32'd0);
    check("reset", "err_flag", 32'(bus0.err_flag), 32'd0);
    check("reset", "total_err", 32'(bus0.total_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset", "in_ready", 32'(bus0.in_ready), 32'd1);

    for (int i = 0; i < 6; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ap,
              vecs[i].sum, vecs[i].cnt, 0, 1'b0);
    end

    run_txn("backpressure", 16'h00FF, 16'h0001, 16'h0000, 16'h0100, 1, 5, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = (i % 3 == 0) ? 16'(~ra + 16'($urandom_range(0, 3))) : 16'($urandom);
      run_txn($sformatf("rand%0d", i), ra, rb, gear_approx(ra, rb), ra + rb,
              expected_errs(ra, rb), int'($urandom_range(0, 2)), 1'b0);
    end

    // Asynchronous reset between edges while the corrector is mid-CHECK.
    check("pre_reset", "total_nonzero", 32'(bus0.total_err != '0), 32'd1);
    a = 16'hFFFF; b = 16'h0001; ap = 16'hFF00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midreset", "out_valid", 32'(bus0.out_valid), 32'd0);
    check("midreset", "total_err", 32'(bus0.total_err), 32'd0);
    check("midreset", "total_err_cnt2", 32'(bus1.total_err), 32'd0);
    exp_t0 = 0; exp_t1 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midreset", "in_ready", 32'(bus0.in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("midreset", "no_stale_result", 32'(bus0.out_valid), 32'd0);

    // Saturation on the 2-bit counter, then clear racing an increment.
    for (int i = 0; i < 4; i++) begin
      run_txn($sformatf("sat%0d", i), 16'h00FF, 16'h0001, 16'h0000, 16'h0100, 1, 0, 1'b0);
    end
    check("sat", "cnt2_saturated", 32'(bus1.total_err), 32'd3);
    check("sat", "cnt16_four", 32'(bus0.total_err), 32'd4);
    run_txn("clr_race", 16'hFFFF, 16'h0001, 16'hFF00, 16'h0000, 2, 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
